// File: rtl/wrr_write_scheduler_if.sv
// Handshake and select bundle between the weighted round-robin write scheduler
// and the surrounding write arbiter (requesters, write master, mux/demux).
interface wrr_write_scheduler_if #(
  parameter int WEIGHT_WIDTH = 4
);
  logic [7:0]                req_i;
  logic [8*WEIGHT_WIDTH-1:0] weight_i;
  logic                      ack_i;
  logic                      done_i;
  logic                      req_o;
  logic [2:0]                mux_sel_o;
  logic [7:0]                grant_o;
  logic                      busy_o;
  logic                      timeout_o;
  logic [2:0]                timeout_ch_o;

  modport slave (
    input  req_i, weight_i, ack_i, done_i,
    output req_o, mux_sel_o, grant_o, busy_o, timeout_o, timeout_ch_o
  );

  modport master (
    output req_i, weight_i, ack_i, done_i,
    input  req_o, mux_sel_o, grant_o, busy_o, timeout_o, timeout_ch_o
  );
endinterface

// File: rtl/wrr_write_scheduler.sv
// Weighted round-robin scheduler sharing one AXI4 write master among 8 requesters,
// with per-channel burst credits and a done watchdog that force-releases the port.
module wrr_write_scheduler #(
  parameter int WEIGHT_WIDTH   = 4,
  parameter int TIMEOUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  sys_clk_i,
  input  logic                  reset_i,
  wrr_write_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, HOLD} state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] EXPIRE_AT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                   r_state, w_stateNext;
  logic [2:0]               r_muxSel, w_muxSelNext;
  logic [2:0]               r_last, w_lastNext;
  logic [2:0]               r_timeoutCh, w_timeoutChNext;
  logic                     r_timeout, w_timeoutNext;
  logic [WEIGHT_WIDTH-1:0]  r_credit, w_creditNext;
  logic [TIMEOUT_WIDTH-1:0] r_watchdog, w_watchdogNext;

  logic                     w_found;
  logic [2:0]               w_pick;
  logic [2:0]               w_idx;
  logic [WEIGHT_WIDTH-1:0]  w_weightRaw;
  logic [WEIGHT_WIDTH-1:0]  w_weightEff;
  logic [WEIGHT_WIDTH-1:0]  w_creditDec;
  logic                     w_expire;

  // Rotating search starting just after the last served channel; k=8 wraps onto last itself.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    w_idx   = r_last;
    for (int k = 1; k <= 8; k++) begin
      w_idx = r_last + 3'(k);
      if (!w_found && bus.req_i[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_weightRaw = bus.weight_i[32'(w_pick) * WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign w_weightEff = (w_weightRaw == '0) ? WEIGHT_WIDTH'(1) : w_weightRaw;
  assign w_creditDec = (r_credit != '0) ? (r_credit - WEIGHT_WIDTH'(1)) : '0;
  assign w_expire    = (r_watchdog == EXPIRE_AT);

  always_comb begin
    w_stateNext     = r_state;
    w_muxSelNext    = r_muxSel;
    w_lastNext      = r_last;
    w_timeoutChNext = r_timeoutCh;
    w_timeoutNext   = 1'b0;
    w_creditNext    = r_credit;
    w_watchdogNext  = r_watchdog;

    case (r_state)
      IDLE: begin
        if (bus.req_i[r_last] && (r_credit != '0)) begin
          w_stateNext    = REQ;
          w_muxSelNext   = r_last;
          w_watchdogNext = '0;
        end else if (w_found) begin
          w_stateNext    = REQ;
          w_muxSelNext   = w_pick;
          w_lastNext     = w_pick;
          w_creditNext   = w_weightEff;
          w_watchdogNext = '0;
        end
      end
      REQ, XFER: begin
        // A done in the expiry cycle takes precedence over the watchdog.
        if (bus.done_i) begin
          w_stateNext  = HOLD;
          w_creditNext = w_creditDec;
        end else if (w_expire) begin
          w_stateNext     = IDLE;
          w_timeoutNext   = 1'b1;
          w_timeoutChNext = r_muxSel;
          w_creditNext    = '0;
        end else begin
          w_watchdogNext = r_watchdog + TIMEOUT_WIDTH'(1);
          if ((r_state == REQ) && bus.ack_i) begin
            w_stateNext = XFER;
          end
        end
      end
      HOLD: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (reset_i) begin
      r_state     <= IDLE;
      r_muxSel    <= 3'd0;
      r_last      <= 3'd7;
      r_timeoutCh <= 3'd0;
      r_timeout   <= 1'b0;
      r_credit    <= '0;
      r_watchdog  <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_muxSel    <= w_muxSelNext;
      r_last      <= w_lastNext;
      r_timeoutCh <= w_timeoutChNext;
      r_timeout   <= w_timeoutNext;
      r_credit    <= w_creditNext;
      r_watchdog  <= w_watchdogNext;
    end
  end

  assign bus.req_o        = (r_state == REQ);
  assign bus.busy_o       = (r_state != IDLE);
  assign bus.mux_sel_o    = r_muxSel;
  assign bus.grant_o      = (r_state != IDLE) ? (8'b1 << r_muxSel) : 8'b0;
  assign bus.timeout_o    = r_timeout;
  assign bus.timeout_ch_o = r_timeoutCh;

endmodule

// File: tb/tb_wrr_write_scheduler.sv
// Self-checking bench for wrr_write_scheduler: hand tables, corner sequences and
// randomized transactions checked against a channel/credit reference model.
module tb_wrr_write_scheduler;
  localparam int WW = 4;
  localparam int TW = 16;
  localparam int TC = 20;

  logic sysClk = 1'b0;
  logic resetIn;
  int   total = 0;
  int   bad   = 0;

  int   mOwner;
  int   mRem;

  typedef struct {
    bit          resetFirst;
    logic [7:0]  req;
    logic [31:0] weights;
    int          ackDelay;
    bit          sameCycle;
    int          doneDelay;
    logic [2:0]  expCh;
  } vec_t;

  vec_t vecs[$];

  always #5 sysClk = ~sysClk;

  wrr_write_scheduler_if #(.WEIGHT_WIDTH(WW)) bus();

  wrr_write_scheduler #(
    .WEIGHT_WIDTH  (WW),
    .TIMEOUT_WIDTH (TW),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .sys_clk_i(sysClk),
    .reset_i  (resetIn),
    .bus      (bus.slave)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] req, input logic [31:0] weights);
    bus.req_i    = req;
    bus.weight_i = weights;
  endtask

  task automatic doReset();
    resetIn    = 1'b1;
    bus.ack_i  = 1'b0;
    bus.done_i = 1'b0;
    applyStimulus(8'h00, 32'h0);
    tick();
    tick();
    checkOutput("rst req_o", 32'(bus.req_o), 0);
    checkOutput("rst mux_sel", 32'(bus.mux_sel_o), 0);
    checkOutput("rst grant", 32'(bus.grant_o), 0);
    checkOutput("rst busy", 32'(bus.busy_o), 0);
    checkOutput("rst timeout", 32'(bus.timeout_o), 0);
    checkOutput("rst timeout_ch", 32'(bus.timeout_ch_o), 0);
    resetIn = 1'b0;
    tick();
    mOwner = 7;
    mRem   = 0;
  endtask

  // Reference: keep serving the owner while it has bursts left, else rotate to the next requester.
  task automatic modelPick(input logic [7:0] req, input logic [31:0] weights, output logic [2:0] ch);
    int c;
    int wv;
    if (req[mOwner] && mRem > 0) begin
      ch = 3'(mOwner);
    end else begin
      c = mOwner;
      for (int k = 1; k <= 8; k++) begin
        if (req[(mOwner + k) % 8]) begin
          c = (mOwner + k) % 8;
          break;
        end
      end
      wv     = int'((weights >> (4 * c)) & 32'hF);
      mOwner = c;
      mRem   = (wv == 0) ? 1 : wv;
      ch     = 3'(c);
    end
  endtask

  task automatic modelDone();
    if (mRem > 0) mRem--;
  endtask

  task automatic runTxn(input string tag, input logic [7:0] req, input logic [31:0] weights,
                        input int ackDelay, input bit sameCycle, input int doneDelay,
                        input logic [2:0] expCh);
    int         waited;
    logic [7:0] g;
    g = 8'b1 << expCh;
    applyStimulus(req, weights);
    bus.ack_i  = 1'b0;
    bus.done_i = 1'b0;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!bus.req_o && waited < 8);
    checkOutput({tag, " req latency"}, 32'(waited), 1);
    checkOutput({tag, " mux_sel"}, 32'(bus.mux_sel_o), 32'(expCh));
    checkOutput({tag, " grant"}, 32'(bus.grant_o), 32'(g));
    for (int i = 0; i < ackDelay; i++) begin
      tick();
      checkOutput({tag, " req held"}, 32'(bus.req_o), 1);
    end
    bus.ack_i  = 1'b1;
    bus.done_i = sameCycle;
    tick();
    bus.ack_i  = 1'b0;
    bus.done_i = 1'b0;
    if (!sameCycle) begin
      checkOutput({tag, " xfer req_o"}, 32'(bus.req_o), 0);
      checkOutput({tag, " xfer busy"}, 32'(bus.busy_o), 1);
      for (int i = 0; i < doneDelay; i++) tick();
      bus.done_i = 1'b1;
      tick();
      bus.done_i = 1'b0;
    end
    checkOutput({tag, " hold busy"}, 32'(bus.busy_o), 1);
    checkOutput({tag, " hold req_o"}, 32'(bus.req_o), 0);
    checkOutput({tag, " hold mux_sel"}, 32'(bus.mux_sel_o), 32'(expCh));
    tick();
    checkOutput({tag, " idle busy"}, 32'(bus.busy_o), 0);
    checkOutput({tag, " idle grant"}, 32'(bus.grant_o), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int         count;
    logic [7:0] rq;
    logic [31:0] rw;
    logic [2:0] ech;

    // Weighted pair: ch0 weight 2, ch1 weight 1.
    vecs.push_back('{1'b1, 8'h03, 32'h0000_0012, 0, 1'b0, 0, 3'd0});
    vecs.push_back('{1'b0, 8'h03, 32'h0000_0012, 0, 1'b0, 0, 3'd0});
    vecs.push_back('{1'b0, 8'h03, 32'h0000_0012, 0, 1'b0, 0, 3'd1});
    vecs.push_back('{1'b0, 8'h03, 32'h0000_0012, 0, 1'b0, 0, 3'd0});
    vecs.push_back('{1'b0, 8'h03, 32'h0000_0012, 0, 1'b0, 0, 3'd0});
    vecs.push_back('{1'b0, 8'h03, 32'h0000_0012, 0, 1'b0, 0, 3'd1});
    // All requesting, zero weights behave as one burst each.
    vecs.push_back('{1'b1, 8'hFF, 32'h0, 0, 1'b0, 0, 3'd0});
    vecs.push_back('{1'b0, 8'hFF, 32'h0, 1, 1'b1, 0, 3'd1});
    vecs.push_back('{1'b0, 8'hFF, 32'h0, 0, 1'b0, 2, 3'd2});
    vecs.push_back('{1'b0, 8'hFF, 32'h0, 2, 1'b0, 1, 3'd3});
    vecs.push_back('{1'b0, 8'hFF, 32'h0, 0, 1'b1, 0, 3'd4});
    vecs.push_back('{1'b0, 8'hFF, 32'h0, 0, 1'b0, 0, 3'd5});
    vecs.push_back('{1'b0, 8'hFF, 32'h0, 1, 1'b0, 1, 3'd6});
    vecs.push_back('{1'b0, 8'hFF, 32'h0, 0, 1'b0, 0, 3'd7});
    vecs.push_back('{1'b0, 8'hFF, 32'h0, 0, 1'b1, 0, 3'd0});

    resetIn = 1'b1;
    bus.ack_i = 1'b0;
    bus.done_i = 1'b0;
    applyStimulus(8'h00, 32'h0);

    // Single request on ch3, ack three cycles after req_o rises.
    doReset();
    runTxn("single", 8'h08, 32'h0, 3, 1'b0, 0, 3'd3);

    foreach (vecs[i]) begin
      if (vecs[i].resetFirst) doReset();
      runTxn($sformatf("vec%0d", i), vecs[i].req, vecs[i].weights, vecs[i].ackDelay,
             vecs[i].sameCycle, vecs[i].doneDelay, vecs[i].expCh);
    end

    // Same-cycle ack+done must consume exactly one credit of ch2's weight of 2.
    doReset();
    runTxn("same1", 8'h04, 32'h0000_0200, 0, 1'b1, 0, 3'd2);
    runTxn("same2", 8'h0C, 32'h0000_0200, 1, 1'b1, 0, 3'd2);
    runTxn("same3", 8'h0C, 32'h0000_0200, 0, 1'b0, 0, 3'd3);

    // Watchdog expiry with done never arriving.
    doReset();
    applyStimulus(8'h12, 32'h0);
    tick();
    checkOutput("wd req_o rise", 32'(bus.req_o), 1);
    checkOutput("wd first sel", 32'(bus.mux_sel_o), 1);
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    count = 1;
    while (!bus.timeout_o && count < 40) begin
      tick();
      count++;
    end
    checkOutput("wd pulse delay", 32'(count), TC);
    checkOutput("wd timeout_ch", 32'(bus.timeout_ch_o), 1);
    checkOutput("wd busy after", 32'(bus.busy_o), 0);
    checkOutput("wd req_o after", 32'(bus.req_o), 0);
    tick();
    checkOutput("wd pulse width", 32'(bus.timeout_o), 0);
    checkOutput("wd next req_o", 32'(bus.req_o), 1);
    checkOutput("wd next sel", 32'(bus.mux_sel_o), 4);

    // Done lands on the expiry cycle: normal HOLD and no pulse.
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    for (int i = 0; i < TC - 2; i++) tick();
    bus.done_i = 1'b1;
    tick();
    bus.done_i = 1'b0;
    checkOutput("wd race hold busy", 32'(bus.busy_o), 1);
    checkOutput("wd race no pulse", 32'(bus.timeout_o), 0);
    tick();
    checkOutput("wd race idle busy", 32'(bus.busy_o), 0);
    checkOutput("wd race no pulse2", 32'(bus.timeout_o), 0);
    checkOutput("wd race ch kept", 32'(bus.timeout_ch_o), 1);

    // Reset while ch5 is in XFER, then ch0 must win first.
    doReset();
    applyStimulus(8'h20, 32'h0);
    tick();
    checkOutput("rx sel", 32'(bus.mux_sel_o), 5);
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    checkOutput("rx xfer busy", 32'(bus.busy_o), 1);
    resetIn = 1'b1;
    tick();
    checkOutput("rx req_o", 32'(bus.req_o), 0);
    checkOutput("rx busy", 32'(bus.busy_o), 0);
    checkOutput("rx mux_sel", 32'(bus.mux_sel_o), 0);
    resetIn = 1'b0;
    applyStimulus(8'h21, 32'h0);
    tick();
    checkOutput("rx first req_o", 32'(bus.req_o), 1);
    checkOutput("rx first sel", 32'(bus.mux_sel_o), 0);
    bus.ack_i  = 1'b1;
    bus.done_i = 1'b1;
    tick();
    bus.ack_i  = 1'b0;
    bus.done_i = 1'b0;
    tick();

    // Randomized transactions against the reference model.
    doReset();
    for (int n = 0; n < 60; n++) begin
      rq = 8'($urandom_range(1, 255));
      rw = $urandom;
      modelPick(rq, rw, ech);
      runTxn($sformatf("rand%0d", n), rq, rw, int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), ech);
      modelDone();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
